// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared types and constants for the ChaCha stream controller
package chacha_pkg;

  localparam int KS_WORDS = 16;
  localparam int WORD_W   = 32;
  localparam int IDX_W    = $clog2(KS_WORDS);
  localparam int KS_W     = KS_WORDS * WORD_W;

  typedef logic [WORD_W-1:0] word_t;

  // One-hot to match the block core FSM style
  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    LAUNCH    = 6'b000010,
    WAIT_CORE = 6'b000100,
    STREAM    = 6'b001000,
    DRAIN     = 6'b010000,
    FINISH    = 6'b100000
  } state_e;

endpackage

// File: rtl/chacha_stream_ctrl_if.sv
// rtl/chacha_stream_ctrl_if.sv - plaintext in / ciphertext out stream handshake bundle
interface chacha_stream_ctrl_if;
  import chacha_pkg::*;

  logic  din_valid_i;
  logic  din_ready_o;
  word_t din_data_i;
  logic  dout_valid_o;
  logic  dout_ready_i;
  word_t dout_data_o;

  modport slave (
    input  din_valid_i, din_data_i, dout_ready_i,
    output din_ready_o, dout_valid_o, dout_data_o
  );

  modport master (
    output din_valid_i, din_data_i, dout_ready_i,
    input  din_ready_o, dout_valid_o, dout_data_o
  );

endinterface

// File: rtl/chacha_ks_buf.sv
// rtl/chacha_ks_buf.sv - 16x32 keystream register file, parallel load, indexed read
module chacha_ks_buf
  import chacha_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [KS_W-1:0]  ks_i,
  input  logic [IDX_W-1:0] idx_i,
  output word_t            word_o
);

  word_t mem [KS_WORDS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < KS_WORDS; k++) mem[k] <= '0;
    end else if (load_i) begin
      for (int k = 0; k < KS_WORDS; k++) mem[k] <= ks_i[k*WORD_W +: WORD_W];
    end
  end

  assign word_o = mem[idx_i];

endmodule

// File: rtl/chacha_stream_ctrl.sv
// rtl/chacha_stream_ctrl.sv - sequences the ChaCha block core and XORs keystream onto a word stream
// Optional: CHACHA_CTR_WRAP_ERR_EN aborts with err_o instead of wrapping the block counter.
module chacha_stream_ctrl
  import chacha_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              msg_start_i,
  input  logic [LEN_W-1:0]  msg_len_i,
  input  logic [31:0]       init_ctr_i,
  output logic              busy_o,
  output logic              msg_done_o,
  output logic              core_start_o,
  input  logic              core_ready_i,
  input  logic              core_done_i,
  input  logic [KS_W-1:0]   core_ks_i,
  output logic [31:0]       core_ctr_o,
  output logic              err_o,
  chacha_stream_ctrl_if.slave strm
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       ctr_q;
  logic              dout_valid_q;
  word_t             dout_data_q;
  word_t             ks_word;
  logic              din_ready;
  logic              din_fire;
  logic              dout_fire;
  logic              last_word;
  logic              blk_end;
  logic              wrap_err;
  logic              ks_load;

  assign din_fire  = strm.din_valid_i && din_ready;
  assign dout_fire = dout_valid_q && strm.dout_ready_i;
  assign last_word = din_fire && (rem_q == LEN_W'(1));
  // Final word of the message wins over block exhaustion: no relaunch, no counter bump
  assign blk_end   = din_fire && (idx_q == IDX_W'(KS_WORDS - 1)) && !last_word;
  assign ks_load   = (state_q == WAIT_CORE) && core_done_i;

`ifdef CHACHA_CTR_WRAP_ERR_EN
  assign wrap_err = blk_end && (ctr_q == 32'hFFFF_FFFF);
`else
  assign wrap_err = 1'b0;
`endif

  chacha_ks_buf u_ks_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (ks_load),
    .ks_i   (core_ks_i),
    .idx_i  (idx_q),
    .word_o (ks_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy_o       = (state_q != IDLE);
    msg_done_o   = (state_q == FINISH);
    core_start_o = (state_q == LAUNCH);
    din_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (msg_start_i) state_d = (msg_len_i == '0) ? FINISH : LAUNCH;
      end
      LAUNCH: begin
        if (core_ready_i) state_d = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (core_done_i) state_d = STREAM;
      end
      STREAM: begin
        din_ready = !dout_valid_q || strm.dout_ready_i;
        if (last_word)     state_d = DRAIN;
        else if (wrap_err) state_d = IDLE;
        else if (blk_end)  state_d = LAUNCH;
      end
      DRAIN: begin
        if (!dout_valid_q || strm.dout_ready_i) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q        <= '0;
      idx_q        <= '0;
      ctr_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      if ((state_q == IDLE) && msg_start_i) begin
        rem_q <= msg_len_i;
        ctr_q <= init_ctr_i;
      end
      if (ks_load) idx_q <= '0;
      if (din_fire) begin
        rem_q       <= rem_q - LEN_W'(1);
        idx_q       <= idx_q + IDX_W'(1);
        dout_valid_q <= 1'b1;
        dout_data_q  <= strm.din_data_i ^ ks_word;
      end else if (dout_fire) begin
        dout_valid_q <= 1'b0;
      end
      if (blk_end && !wrap_err) ctr_q <= ctr_q + 32'd1;
    end
  end

`ifdef CHACHA_CTR_WRAP_ERR_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= wrap_err;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign core_ctr_o        = ctr_q;
  assign strm.din_ready_o  = din_ready;
  assign strm.dout_valid_o = dout_valid_q;
  assign strm.dout_data_o  = dout_data_q;

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// tb/tb_chacha_stream_ctrl.sv - table-driven scoreboard bench for chacha_stream_ctrl
module tb_chacha_stream_ctrl;
  import chacha_pkg::*;

`ifdef CHACHA_CTR_WRAP_ERR_EN
  localparam int WRAP_ERR = 1;
`else
  localparam int WRAP_ERR = 0;
`endif
  localparam int LEN_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             msg_start_i = 1'b0;
  logic [LEN_W-1:0] msg_len_i = '0;
  logic [31:0]      init_ctr_i = '0;
  logic             busy_o, msg_done_o, core_start_o, err_o;
  logic             core_ready_i = 1'b0;
  logic             core_done_i = 1'b0;
  logic [KS_W-1:0]  core_ks_i = '0;
  logic [31:0]      core_ctr_o;

  chacha_stream_ctrl_if sif ();

  chacha_stream_ctrl #(.LEN_W(LEN_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .msg_start_i  (msg_start_i),
    .msg_len_i    (msg_len_i),
    .init_ctr_i   (init_ctr_i),
    .busy_o       (busy_o),
    .msg_done_o   (msg_done_o),
    .core_start_o (core_start_o),
    .core_ready_i (core_ready_i),
    .core_done_i  (core_done_i),
    .core_ks_i    (core_ks_i),
    .core_ctr_o   (core_ctr_o),
    .err_o        (err_o),
    .strm         (sif)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          len;
    logic [31:0] ctr;
    int          rmode;
    int          stall;
    int          spur;
    int          rst_at;
    int          starts;
    int          dones;
    int          errs;
    int          words;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic quiet();
    msg_start_i      = 1'b0;
    sif.din_valid_i  = 1'b0;
    sif.din_data_i   = '0;
    sif.dout_ready_i = 1'b1;
    core_done_i      = 1'b0;
    core_ready_i     = 1'b1;
  endtask

  task automatic run_msg(input vec_t v);
    int          nstarts = 0, ndone = 0, nerr = 0, nbusy = 0;
    int          nin = 0, nout = 0, last_out = -10, end_cnt = -1, cnt = 0;
    int          widx = KS_WORDS;
    int          stall_left = v.stall;
    bit          core_busy = 0, stall_seen = 0, spur_done = 0, finished = 0;
    logic [31:0] cur_ks[KS_WORDS];
    logic [31:0] pend[KS_WORDS];
    logic [31:0] exp_ctr;
    exp_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk_i);
      msg_start_i      = (cyc == 0);
      msg_len_i        = LEN_W'(v.len);
      init_ctr_i       = v.ctr;
      sif.din_valid_i  = (v.rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      sif.din_data_i   = $urandom;
      sif.dout_ready_i = (v.rmode == 0) ? 1'b1 :
                         (v.rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      core_done_i      = 1'b0;
      if (core_busy) begin
        cnt--;
        if (cnt == 0) begin
          core_done_i = 1'b1;
          for (int k = 0; k < KS_WORDS; k++) core_ks_i[k*32 +: 32] = pend[k];
        end
      end else if (v.spur != 0 && !spur_done && widx >= 3 && widx <= 10) begin
        core_done_i = 1'b1;
        for (int k = 0; k < KS_WORDS; k++) core_ks_i[k*32 +: 32] = $urandom;
        spur_done = 1;
      end
      core_ready_i = !core_busy && (stall_left == 0);
      #1;
      if (busy_o) nbusy++;
      if (sif.dout_valid_o && !sif.dout_ready_i) check("bp_din_ready", 64'(sif.din_ready_o), 64'(0));
      if (stall_left > 0 && (stall_seen || core_start_o)) begin
        stall_seen = 1;
        check("stall_start_held", 64'(core_start_o), 64'(1));
        stall_left--;
      end
      if (core_busy && core_done_i) begin
        cur_ks    = pend;
        widx      = 0;
        core_busy = 0;
      end
      if (core_start_o && core_ready_i) begin
        exp_ctr = v.ctr + 32'(nstarts);
        check("core_ctr", 64'(core_ctr_o), 64'(exp_ctr));
        nstarts++;
        core_busy = 1;
        cnt = 3;
        for (int k = 0; k < KS_WORDS; k++) pend[k] = $urandom;
      end
      if (sif.din_valid_i && sif.din_ready_o) begin
        if (widx < KS_WORDS) exp_q.push_back(sif.din_data_i ^ cur_ks[widx]);
        else check("ks_available", 64'(widx), 64'(KS_WORDS - 1));
        widx++;
        nin++;
      end
      if (sif.dout_valid_o && sif.dout_ready_i) begin
        if (exp_q.size() == 0) check("dout_extra_word", 64'(sif.dout_data_o), 64'(0) - 64'(1));
        else check("dout_data", 64'(sif.dout_data_o), 64'(exp_q.pop_front()));
        nout++;
        last_out = cyc;
      end
      if (msg_done_o) begin
        ndone++;
        if (v.len == 0) check("zero_done_cycle", 64'(cyc), 64'(1));
        else check("done_after_last_dout", 64'(cyc - last_out), 64'(1));
      end
      if (err_o) begin
        nerr++;
        check("err_after_word16", 64'(nin), 64'(16));
      end
      if (v.rst_at > 0 && nout == v.rst_at) begin
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_ctl_outputs", 64'({busy_o, msg_done_o, core_start_o, sif.din_ready_o,
                                      sif.dout_valid_o, err_o}), 64'(0));
        check("rst_data_outputs", {core_ctr_o, sif.dout_data_o}, 64'(0));
        @(negedge clk_i);
        quiet();
        rst_ni = 1'b1;
        finished = 1;
        break;
      end
      if ((msg_done_o || err_o) && end_cnt < 0) end_cnt = 4;
      if (end_cnt > 0) end_cnt--;
      if (end_cnt == 0) begin
        finished = 1;
        break;
      end
    end
    if (!finished) check("msg_timeout", 64'(0), 64'(1));
    check("num_core_starts", 64'(nstarts), 64'(v.starts));
    check("num_done_pulses", 64'(ndone), 64'(v.dones));
    check("num_err_pulses", 64'(nerr), 64'(v.errs));
    if (v.rst_at == 0) begin
      check("num_dout_words", 64'(nout), 64'(v.words));
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    end
    if (v.len == 0) check("zero_busy_cycles", 64'(nbusy), 64'(1));
    exp_q.delete();
    @(negedge clk_i);
    quiet();
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    //          len ctr            rmode stall spur rst starts          dones           errs      words
    vecs[0] = '{5,  32'd7,         0,    0,    0,   0,  1,              1,              0,        5};
    vecs[1] = '{40, 32'd0,         0,    0,    0,   0,  3,              1,              0,        40};
    vecs[2] = '{0,  32'd9,         0,    0,    0,   0,  0,              1,              0,        0};
    vecs[3] = '{16, 32'd100,       1,    0,    0,   0,  1,              1,              0,        16};
    vecs[4] = '{20, 32'd5,         2,    10,   1,   0,  2,              1,              0,        20};
    vecs[5] = '{17, 32'hFFFF_FFFF, 0,    0,    0,   0,  2 - WRAP_ERR,   1 - WRAP_ERR,   WRAP_ERR, 17 - WRAP_ERR};
    vecs[6] = '{33, 32'd3,         2,    0,    0,   0,  3,              1,              0,        33};
    vecs[7] = '{30, 32'd0,         0,    0,    0,   5,  1,              0,              0,        0};

    quiet();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("reset_ctl", 64'({busy_o, msg_done_o, core_start_o, sif.din_ready_o,
                            sif.dout_valid_o, err_o}), 64'(0));
    check("reset_data", {core_ctr_o, sif.dout_data_o}, 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 8; i++) run_msg(vecs[i]);

    // Hand sequence: zero-length message, cycle by cycle
    @(negedge clk_i);
    msg_start_i = 1'b1;
    msg_len_i   = '0;
    init_ctr_i  = 32'h55;
    #1;
    check("zl_busy_c0", 64'(busy_o), 64'(0));
    @(negedge clk_i);
    msg_start_i = 1'b0;
    #1;
    check("zl_busy_c1", 64'(busy_o), 64'(1));
    check("zl_done_c1", 64'(msg_done_o), 64'(1));
    check("zl_nostart_c1", 64'(core_start_o), 64'(0));
    @(negedge clk_i);
    #1;
    check("zl_busy_c2", 64'(busy_o), 64'(0));
    check("zl_done_c2", 64'(msg_done_o), 64'(0));

    // Hand sequence: msg_start while busy is ignored
    @(negedge clk_i);
    msg_start_i  = 1'b1;
    msg_len_i    = LEN_W'(3);
    core_ready_i = 1'b0;
    @(negedge clk_i);
    msg_start_i = 1'b1;
    msg_len_i   = '0;
    #1;
    check("busy_launch", 64'(core_start_o), 64'(1));
    @(negedge clk_i);
    msg_start_i = 1'b0;
    #1;
    check("restart_ignored", 64'({busy_o, core_start_o, msg_done_o}), 64'(3'b110));
    rst_ni = 1'b0;
    @(negedge clk_i);
    quiet();
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    check("idle_after_rst", 64'(busy_o), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
